// File: rtl/cr16_pipe_datapath_if.sv
// Issue/result bus between the CR16 controller and the pipelined datapath.
// master = controller side, slave = datapath side.
interface cr16_pipe_datapath_if #(
  parameter int unsigned P_WIDTH    = 16,
  parameter int unsigned P_NUM_REGS = 16
);
  localparam int unsigned P_SEL_WIDTH = $clog2(P_NUM_REGS);

  logic                   i_stall;
  logic                   i_valid;
  logic [3:0]             i_opcode;
  logic [P_SEL_WIDTH-1:0] i_reg_a_select;
  logic [P_SEL_WIDTH-1:0] i_reg_b_select;
  logic [P_SEL_WIDTH-1:0] i_reg_dest;
  logic                   i_write_enable;
  logic                   i_immediate_select;
  logic [P_WIDTH-1:0]     i_immediate;
  logic [P_SEL_WIDTH-1:0] i_debug_select;
  logic [P_WIDTH-1:0]     o_debug_data;
  logic [P_WIDTH-1:0]     o_result_bus;
  logic                   o_result_valid;
  logic [4:0]             o_status_flags;

  modport master (
    output i_stall, i_valid, i_opcode, i_reg_a_select, i_reg_b_select, i_reg_dest,
           i_write_enable, i_immediate_select, i_immediate, i_debug_select,
    input  o_debug_data, o_result_bus, o_result_valid, o_status_flags
  );

  modport slave (
    input  i_stall, i_valid, i_opcode, i_reg_a_select, i_reg_b_select, i_reg_dest,
           i_write_enable, i_immediate_select, i_immediate, i_debug_select,
    output o_debug_data, o_result_bus, o_result_valid, o_status_flags
  );
endinterface

// File: rtl/cr16_pipe_datapath.sv
// Two-stage CR16 datapath: READ captures operands (with EXEC forwarding),
// EXEC runs the ALU, writes the register file and updates {N,Z,F,L,C}.
module cr16_pipe_datapath #(
  parameter int unsigned P_WIDTH    = 16,
  parameter int unsigned P_NUM_REGS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_nreset,
  cr16_pipe_datapath_if.slave   bus
);
  localparam int unsigned P_SEL_WIDTH = $clog2(P_NUM_REGS);
  localparam int unsigned SH_W        = $clog2(P_WIDTH);
  localparam int unsigned FLAG_N = 4, FLAG_Z = 3, FLAG_F = 2, FLAG_L = 1, FLAG_C = 0;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_NOT = 4'd5, OP_LSH = 4'd6, OP_RSH = 4'd7,
                         OP_ASH = 4'd8, OP_CMP = 4'd9, OP_MOV = 4'd10;

  logic [P_WIDTH-1:0]     r_regs [P_NUM_REGS];
  logic                   r_rd_valid;
  logic [3:0]             r_rd_op;
  logic [P_WIDTH-1:0]     r_rd_a;
  logic [P_WIDTH-1:0]     r_rd_b;
  logic [P_SEL_WIDTH-1:0] r_rd_dest;
  logic                   r_rd_we;
  logic [P_WIDTH-1:0]     r_result;
  logic                   r_result_valid;
  logic [4:0]             r_flags;

  logic [P_WIDTH:0]       w_sum;
  logic [P_WIDTH:0]       w_diff;
  logic [SH_W-1:0]        w_shamt;
  logic [P_WIDTH-1:0]     w_result;
  logic                   w_writes;
  logic [4:0]             w_flags_nxt;
  logic                   w_fwd_en;
  logic [P_WIDTH-1:0]     w_reg_a;
  logic [P_WIDTH-1:0]     w_reg_b;

  // ALU: result = B op A, carry/borrow taken from bit P_WIDTH
  always_comb begin
    w_sum       = {1'b0, r_rd_b} + {1'b0, r_rd_a};
    w_diff      = {1'b0, r_rd_b} - {1'b0, r_rd_a};
    w_shamt     = r_rd_a[SH_W-1:0];
    w_result    = '0;
    w_writes    = 1'b1;
    w_flags_nxt = r_flags;
    case (r_rd_op)
      OP_ADD: begin
        w_result            = w_sum[P_WIDTH-1:0];
        w_flags_nxt[FLAG_C] = w_sum[P_WIDTH];
        w_flags_nxt[FLAG_F] = (r_rd_a[P_WIDTH-1] == r_rd_b[P_WIDTH-1]) &&
                              (w_sum[P_WIDTH-1] != r_rd_b[P_WIDTH-1]);
      end
      OP_SUB: begin
        w_result            = w_diff[P_WIDTH-1:0];
        w_flags_nxt[FLAG_C] = w_diff[P_WIDTH];
        w_flags_nxt[FLAG_F] = (r_rd_a[P_WIDTH-1] != r_rd_b[P_WIDTH-1]) &&
                              (w_diff[P_WIDTH-1] != r_rd_b[P_WIDTH-1]);
      end
      OP_AND: w_result = r_rd_b & r_rd_a;
      OP_OR:  w_result = r_rd_b | r_rd_a;
      OP_XOR: w_result = r_rd_b ^ r_rd_a;
      OP_NOT: w_result = ~r_rd_a;
      OP_LSH: w_result = r_rd_b << w_shamt;
      OP_RSH: w_result = r_rd_b >> w_shamt;
      OP_ASH: w_result = P_WIDTH'($signed(r_rd_b) >>> w_shamt);
      OP_CMP: begin
        w_result            = w_diff[P_WIDTH-1:0];
        w_writes            = 1'b0;
        w_flags_nxt[FLAG_Z] = (r_rd_b == r_rd_a);
        w_flags_nxt[FLAG_L] = w_diff[P_WIDTH];
        w_flags_nxt[FLAG_N] = ($signed(r_rd_b) < $signed(r_rd_a));
      end
      OP_MOV: w_result = r_rd_a;
      default: begin
        w_result = '0;
        w_writes = 1'b0;
      end
    endcase
  end

  // EXEC result bypasses the register file, so it also wins over a same-cycle write
  always_comb begin
    w_fwd_en = r_rd_valid && r_rd_we && w_writes;
    w_reg_a  = (w_fwd_en && (r_rd_dest == bus.i_reg_a_select)) ? w_result
                                                              : r_regs[bus.i_reg_a_select];
    w_reg_b  = (w_fwd_en && (r_rd_dest == bus.i_reg_b_select)) ? w_result
                                                              : r_regs[bus.i_reg_b_select];
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      for (int i = 0; i < int'(P_NUM_REGS); i++) r_regs[i] <= '0;
      r_rd_valid     <= 1'b0;
      r_rd_op        <= '0;
      r_rd_a         <= '0;
      r_rd_b         <= '0;
      r_rd_dest      <= '0;
      r_rd_we        <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_flags        <= '0;
    end else if (!bus.i_stall) begin
      r_rd_valid <= bus.i_valid;
      r_rd_op    <= bus.i_opcode;
      r_rd_a     <= bus.i_immediate_select ? bus.i_immediate : w_reg_a;
      r_rd_b     <= w_reg_b;
      r_rd_dest  <= bus.i_reg_dest;
      r_rd_we    <= bus.i_write_enable;
      if (r_rd_valid) begin
        if (w_fwd_en) r_regs[r_rd_dest] <= w_result;
        r_result       <= w_result;
        r_result_valid <= 1'b1;
        r_flags        <= w_flags_nxt;
      end else begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign bus.o_debug_data   = r_regs[bus.i_debug_select];
  assign bus.o_result_bus   = r_result;
  assign bus.o_result_valid = r_result_valid;
  assign bus.o_status_flags = r_flags;
endmodule

// File: tb/tb_cr16_pipe_datapath.sv
// Self-checking bench: directed vector table, stall/reset sequences, random ops
// against an ISA-level sequential model, and a 32-bit/8-register instance.
module tb_cr16_pipe_datapath;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cr16_pipe_datapath_if #(.P_WIDTH(16), .P_NUM_REGS(16)) b16 ();
  cr16_pipe_datapath_if #(.P_WIDTH(32), .P_NUM_REGS(8))  b32 ();

  cr16_pipe_datapath #(.P_WIDTH(16), .P_NUM_REGS(16)) dut16 (
    .i_clk(clk), .i_nreset(rst_n), .bus(b16.slave));
  cr16_pipe_datapath #(.P_WIDTH(32), .P_NUM_REGS(8)) dut32 (
    .i_clk(clk), .i_nreset(rst_n), .bus(b32.slave));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  a, b, d;
    logic        we, isel;
    logic [15:0] imm;
    logic        rv;
    logic [15:0] res;
    logic [4:0]  fl;
  } vec_t;

  vec_t tbl [12];

  // sequential (ISA-level) model state for the 16-bit instance
  logic [15:0] m_arch [16];
  logic [15:0] m_commit [16];
  logic [4:0]  m_fl;
  logic        p_v, p_wr;
  logic [3:0]  p_d;
  logic [63:0] p_res;
  logic [4:0]  p_fl;
  logic        e_rv;
  logic [15:0] e_res;
  logic [4:0]  e_fl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] d, input logic we,
                              input logic isel, input logic [15:0] imm, input logic rv,
                              input logic [15:0] res, input logic [4:0] fl);
    vec_t t;
    t.valid = v; t.op = op; t.a = a; t.b = b; t.d = d; t.we = we; t.isel = isel;
    t.imm = imm; t.rv = rv; t.res = res; t.fl = fl;
    return t;
  endfunction

  // Reference ALU from the opcode rules, using plain integer arithmetic at width w
  function automatic void ref_alu(input int w, input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic [4:0] fin,
                                  output logic [63:0] res, output logic [4:0] fout,
                                  output logic wr);
    logic [63:0] mask;
    longint sa, sb, s, hi, lo;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    sa = $signed(a); if (a[w-1]) sa = sa - $signed(64'd1 << w);
    sb = $signed(b); if (b[w-1]) sb = sb - $signed(64'd1 << w);
    hi = $signed(64'd1 << (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    sh = int'(a & 64'(w - 1));
    res = '0; fout = fin; wr = 1'b1;
    case (op)
      4'd0: begin res = (b + a) & mask; fout[0] = ((b + a) >> w) != 0;
                  s = sb + sa; fout[2] = (s > hi) || (s < lo); end
      4'd1: begin res = (b - a) & mask; fout[0] = (b < a);
                  s = sb - sa; fout[2] = (s > hi) || (s < lo); end
      4'd2: res = b & a;
      4'd3: res = b | a;
      4'd4: res = b ^ a;
      4'd5: res = ~a & mask;
      4'd6: res = (b << sh) & mask;
      4'd7: res = b >> sh;
      4'd8: res = $unsigned(sb >>> sh) & mask;
      4'd9: begin res = (b - a) & mask; wr = 1'b0;
                  fout[3] = (a == b); fout[1] = (b < a); fout[4] = (sb < sa); end
      4'd10: res = a;
      default: begin res = '0; wr = 1'b0; end
    endcase
  endfunction

  task automatic drive16(input logic st, input logic v, input logic [3:0] op,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         input logic we, input logic isel, input logic [15:0] imm);
    b16.i_stall = st; b16.i_valid = v; b16.i_opcode = op;
    b16.i_reg_a_select = a; b16.i_reg_b_select = b; b16.i_reg_dest = d;
    b16.i_write_enable = we; b16.i_immediate_select = isel; b16.i_immediate = imm;
  endtask

  task automatic drive32(input logic v, input logic [3:0] op, input logic [2:0] b,
                         input logic [2:0] d, input logic [31:0] imm);
    b32.i_stall = 1'b0; b32.i_valid = v; b32.i_opcode = op;
    b32.i_reg_a_select = 3'd0; b32.i_reg_b_select = b; b32.i_reg_dest = d;
    b32.i_write_enable = 1'b1; b32.i_immediate_select = 1'b1; b32.i_immediate = imm;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // one cycle of 16-bit stimulus with the model advanced alongside
  task automatic step16(input logic st, input logic v, input logic [3:0] op,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic we, input logic isel, input logic [15:0] imm,
                        input logic [3:0] dbg);
    logic [63:0] r, opa;
    logic [4:0]  f;
    logic        wr;
    drive16(st, v, op, a, b, d, we, isel, imm);
    b16.i_debug_select = dbg;
    if (!st) begin
      if (p_v) begin
        e_rv = 1'b1; e_res = p_res[15:0]; e_fl = p_fl;
        if (p_wr) m_commit[p_d] = p_res[15:0];
      end else e_rv = 1'b0;
      p_v = v;
      if (v) begin
        opa = isel ? 64'(imm) : 64'(m_arch[a]);
        ref_alu(16, op, opa, 64'(m_arch[b]), m_fl, r, f, wr);
        p_res = r; p_fl = f; m_fl = f; p_wr = wr && we; p_d = d;
        if (p_wr) m_arch[d] = r[15:0];
      end
    end
    tick();
    check("rnd_valid", 64'(b16.o_result_valid), 64'(e_rv));
    check("rnd_result", 64'(b16.o_result_bus), 64'(e_res));
    check("rnd_flags", 64'(b16.o_status_flags), 64'(e_fl));
    check("rnd_debug", 64'(b16.o_debug_data), 64'(m_commit[dbg]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] imm;
    rst_n = 1'b0;
    drive16(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0);
    b16.i_debug_select = 4'd0;
    drive32(1'b0, 4'd0, 3'd0, 3'd0, 32'h0);
    b32.i_debug_select = 3'd0;

    // directed table: expected outputs are those seen after the edge applying the row
    tbl[0]  = mk(1'b1, 4'd10, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 16'h0005, 1'b0, 16'h0000, 5'b00000);
    tbl[1]  = mk(1'b1, 4'd10, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0005, 5'b00000);
    tbl[2]  = mk(1'b1, 4'd1,  4'd2, 4'd1, 4'd1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 5'b00000);
    tbl[3]  = mk(1'b0, 4'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 5'b00000);
    tbl[4]  = mk(1'b1, 4'd10, 4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 16'h7FFF, 1'b0, 16'h0002, 5'b00000);
    tbl[5]  = mk(1'b1, 4'd0,  4'd0, 4'd3, 4'd3, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h7FFF, 5'b00000);
    tbl[6]  = mk(1'b1, 4'd10, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h8000, 5'b00100);
    tbl[7]  = mk(1'b1, 4'd0,  4'd0, 4'd4, 4'd4, 1'b1, 1'b1, 16'h0001, 1'b1, 16'hFFFF, 5'b00100);
    tbl[8]  = mk(1'b1, 4'd10, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 16'h8000, 1'b1, 16'h0000, 5'b00001);
    tbl[9]  = mk(1'b1, 4'd9,  4'd0, 4'd5, 4'd5, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h8000, 5'b00001);
    tbl[10] = mk(1'b0, 4'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7FFF, 5'b10001);
    tbl[11] = mk(1'b0, 4'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h7FFF, 5'b10001);

    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 64'(b16.o_result_bus), 64'h0);
    check("rst_valid", 64'(b16.o_result_valid), 64'h0);
    check("rst_flags", 64'(b16.o_status_flags), 64'h0);
    for (int i = 0; i < 16; i++) begin
      b16.i_debug_select = 4'(i); #1;
      check("rst_reg", 64'(b16.o_debug_data), 64'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      drive16(1'b0, tbl[i].valid, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d,
              tbl[i].we, tbl[i].isel, tbl[i].imm);
      tick();
      check("tbl_valid", 64'(b16.o_result_valid), 64'(tbl[i].rv));
      check("tbl_result", 64'(b16.o_result_bus), 64'(tbl[i].res));
      check("tbl_flags", 64'(b16.o_status_flags), 64'(tbl[i].fl));
    end
    begin
      logic [15:0] exp_regs [6];
      exp_regs = '{16'h0, 16'h0002, 16'h0003, 16'h8000, 16'h0000, 16'h8000};
      for (int i = 1; i < 6; i++) begin
        b16.i_debug_select = 4'(i); #1;
        check("tbl_reg", 64'(b16.o_debug_data), 64'(exp_regs[i]));
      end
    end

    // stall with an ADD in flight; ops presented during the stall are dropped
    b16.i_debug_select = 4'd2;
    drive16(1'b0, 1'b1, 4'd10, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 16'h0011); tick();
    check("stl_pre_valid", 64'(b16.o_result_valid), 64'h0);
    drive16(1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 4'd2, 1'b1, 1'b1, 16'h0002); tick();
    check("stl_pre_result", 64'(b16.o_result_bus), 64'h0011);
    for (int i = 0; i < 3; i++) begin
      drive16(1'b1, 1'b1, 4'd10, 4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 16'h0055); tick();
      check("stl_valid", 64'(b16.o_result_valid), 64'h1);
      check("stl_result", 64'(b16.o_result_bus), 64'h0011);
      check("stl_flags", 64'(b16.o_status_flags), 64'h11);
      check("stl_noreg", 64'(b16.o_debug_data), 64'h0003);
    end
    drive16(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0); tick();
    check("stl_rel_valid", 64'(b16.o_result_valid), 64'h1);
    check("stl_rel_result", 64'(b16.o_result_bus), 64'h0005);
    check("stl_rel_flags", 64'(b16.o_status_flags), 64'h10);
    check("stl_rel_reg", 64'(b16.o_debug_data), 64'h0005);
    tick();
    check("stl_end_valid", 64'(b16.o_result_valid), 64'h0);
    b16.i_debug_select = 4'd6; #1;
    check("stl_dropped", 64'(b16.o_debug_data), 64'h0);
    b16.i_debug_select = 4'd7; #1;
    check("stl_r7", 64'(b16.o_debug_data), 64'h0011);

    // reset asserted with one op completed and another in flight
    drive16(1'b0, 1'b1, 4'd10, 4'd0, 4'd0, 4'd8, 1'b1, 1'b1, 16'h00AA); tick();
    drive16(1'b0, 1'b1, 4'd10, 4'd0, 4'd0, 4'd9, 1'b1, 1'b1, 16'h00BB); tick();
    check("mrst_pre_valid", 64'(b16.o_result_valid), 64'h1);
    drive16(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0);
    rst_n = 1'b0; #1;
    check("mrst_result", 64'(b16.o_result_bus), 64'h0);
    check("mrst_valid", 64'(b16.o_result_valid), 64'h0);
    check("mrst_flags", 64'(b16.o_status_flags), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    for (int i = 7; i < 10; i++) begin
      b16.i_debug_select = 4'(i); #1;
      check("mrst_reg", 64'(b16.o_debug_data), 64'h0);
    end
    check("mrst_idle_valid", 64'(b16.o_result_valid), 64'h0);

    // random ops against the sequential model, starting from the reset state
    for (int i = 0; i < 16; i++) begin m_arch[i] = '0; m_commit[i] = '0; end
    m_fl = '0; p_v = 1'b0; p_wr = 1'b0; p_d = '0; p_res = '0; p_fl = '0;
    e_rv = 1'b0; e_res = '0; e_fl = '0;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 5))
        0: imm = 16'h0000;
        1: imm = 16'h0001;
        2: imm = 16'h7FFF;
        3: imm = 16'h8000;
        4: imm = 16'hFFFF;
        default: imm = 16'($urandom);
      endcase
      step16($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
             4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, imm, 4'($urandom));
    end
    for (int i = 0; i < 16; i++)
      step16(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 4'(i));

    // 32-bit / 8-register instance: shifts at the width boundary and a reserved opcode
    b32.i_debug_select = 3'd3;
    drive32(1'b1, 4'd10, 3'd0, 3'd1, 32'h8000_0000); tick();
    check("w32_valid0", 64'(b32.o_result_valid), 64'h0);
    drive32(1'b1, 4'd8, 3'd1, 3'd1, 32'd4); tick();
    check("w32_mov", 64'(b32.o_result_bus), 64'h8000_0000);
    drive32(1'b1, 4'd10, 3'd0, 3'd2, 32'd1); tick();
    check("w32_ash", 64'(b32.o_result_bus), 64'hF800_0000);
    drive32(1'b1, 4'd6, 3'd2, 3'd2, 32'd31); tick();
    check("w32_mov1", 64'(b32.o_result_bus), 64'h1);
    drive32(1'b1, 4'd13, 3'd0, 3'd3, 32'h1234); tick();
    check("w32_lsh", 64'(b32.o_result_bus), 64'h8000_0000);
    drive32(1'b0, 4'd0, 3'd0, 3'd0, 32'h0); tick();
    check("w32_rsv_result", 64'(b32.o_result_bus), 64'h0);
    check("w32_rsv_valid", 64'(b32.o_result_valid), 64'h1);
    check("w32_rsv_nowrite", 64'(b32.o_debug_data), 64'h0);
    tick();
    check("w32_idle_valid", 64'(b32.o_result_valid), 64'h0);
    check("w32_flags", 64'(b32.o_status_flags), 64'h0);
    b32.i_debug_select = 3'd1; #1;
    check("w32_r1", 64'(b32.o_debug_data), 64'hF800_0000);
    b32.i_debug_select = 3'd2; #1;
    check("w32_r2", 64'(b32.o_debug_data), 64'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cr16_pipe_datapath.md
Name: cr16_pipe_datapath

Overview:
Parametrised, two-stage pipelined successor to the single-cycle CR16 datapath. It contains a register file (depth and width set by parameters), an operand-A immediate mux, an internal ALU and a flag register.
- Stage 1 (READ) registers the operands.
- Stage 2 (EXEC) computes, writes back and updates flags.
- EXEC-to-READ forwarding removes the back-to-back RAW hazard.
- A global stall freezes the pipe.

It sits between the CR16 controller/decoder and the memory interface.

Parameters:
P_WIDTH, 16, datapath and register width in bits (≥4, power of two)
P_NUM_REGS, 16, number of general registers (power of two, ≥2)
P_SEL_WIDTH, $clog2(P_NUM_REGS), register-select width (derived localparam, not overridable)

Ports:
I_CLK  input  1  clock; all state changes on rising edge
I_NRESET  input  1  asynchronous active-low reset
I_STALL  input  1  1 = freeze both stages (no capture, no writeback, no flag update)
I_VALID  input  1  issue strobe; operation captured into READ when high and not stalled
I_OPCODE  input  4  ALU operation (table below)
I_REG_A_SELECT  input  P_SEL_WIDTH  source register for operand A
I_REG_B_SELECT  input  P_SEL_WIDTH  source register for operand B
I_REG_DEST  input  P_SEL_WIDTH  writeback destination
I_WRITE_ENABLE  input  1  1 = write result to I_REG_DEST
I_IMMEDIATE_SELECT  input  1  1 = operand A is I_IMMEDIATE, 0 = register A
I_IMMEDIATE  input  P_WIDTH  immediate operand
I_DEBUG_SELECT  input  P_SEL_WIDTH  register for debug readout
O_DEBUG_DATA  output  P_WIDTH  combinational contents of register I_DEBUG_SELECT (no forwarding)
O_RESULT_BUS  output  P_WIDTH  registered result of last completed op
O_RESULT_VALID  output  1  1-cycle pulse when O_RESULT_BUS updates
O_STATUS_FLAGS  output  5  {N,Z,F,L,C} = bits [4:0] = N,Z,F,L,C from MSB to LSB

Behaviour:
- Reset (async, I_NRESET=0): all registers, READ/EXEC pipeline registers and valid bits, O_RESULT_BUS, O_RESULT_VALID and O_STATUS_FLAGS are cleared to 0 immediately. In-flight ops are discarded. Operation resumes on the first edge after deassertion.
- READ capture (edge, !I_STALL):
  - stage-1 valid <= I_VALID.
  - Operand A <= immediate or forwarded reg A.
  - Operand B <= forwarded reg B.
  - Opcode, dest and write-enable are captured alongside.
  - I_VALID=0 inserts a bubble.
- Forwarding: when EXEC is valid and writing (write enable, opcode writes) and its dest equals a read select, the operand takes the ALU result of that cycle instead of the register-file value. The immediate path is never forwarded.
- EXEC (edge, !I_STALL, stage valid):
  - Register-file write of the result, if enabled and the opcode writes.
  - O_RESULT_BUS <= result; O_RESULT_VALID <= 1.
  - Flags update per the opcode rules.
  - If EXEC is a bubble, O_RESULT_VALID <= 0 and all other state is held.
- Latency: issue at edge k, result/regfile/flags visible after edge k+1. Throughput is 1 op/cycle.
- Stall: all state is held and O_RESULT_VALID holds its value. I_VALID is ignored (the caller must re-present the op). Forwarding compares remain live.
- Operand orientation: A = source/immediate, B = destination operand. Result is computed as B op A at P_WIDTH; the carry is bit P_WIDTH.
- Opcodes:
  - 0 ADD: B+A. C = carry out, F = signed overflow.
  - 1 SUB: B−A. C = borrow, F = signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 NOT: ~A.
  - 6 LSH: B << A[log2(P_WIDTH)-1:0].
  - 7 RSH: logical right shift.
  - 8 ASH: arithmetic right shift.
  - 9 CMP: result B−A, no register write regardless of I_WRITE_ENABLE. Z = (B==A), L = (B<A unsigned), N = (B<A signed).
  - 10 MOV: A.
  - 11–15 reserved: result 0, no write, no flag change, O_RESULT_VALID still pulses.
- Flag rules: C and F change only on ADD/SUB. Z, L and N change only on CMP. All other opcodes hold all flags.
- Simultaneous EXEC write and READ of the same register: the forwarded value wins.
- O_DEBUG_DATA reflects the register file only; it updates the cycle after writeback.

Test Plan:
- Reset then idle: O_RESULT_BUS=0, O_STATUS_FLAGS=0, every I_DEBUG_SELECT reads 0; assert I_NRESET low mid-op → outputs 0 immediately, no write lands.
- MOV imm 0x0005→R1, then MOV imm 0x0003→R2, then SUB A=R2,B=R1,dest R1 (back-to-back) → forwarding gives R1=0x0002, C=0, F=0, results valid after edges 2,3,4.
- ADD imm 0x0001 to R3=0x7FFF, dest R3 → R3=0x8000, F=1, C=0; ADD imm 0x0001 to R4=0xFFFF → R4=0x0000, C=1, F=0.
- CMP R5=0x8000 vs imm 0x0001, I_WRITE_ENABLE=1 → R5 unchanged, Z=0, L=0, N=1; C/F unchanged from previous op.
- I_STALL high 3 cycles with an ADD in EXEC → no write, O_RESULT_BUS held, flags held; completes one edge after release. Ops issued during the stall are dropped.
- Parameter sweep P_WIDTH=32, P_NUM_REGS=8: ASH 0x80000000 by 4 → 0xF8000000; LSH 0x1 by 31 → 0x80000000; reserved opcode 13 → result 0, no write.
